frame_write_sequencer: RTL and testbench

- Sits directly upstream of the dual frame buffer.
- Accepts batches of FMA_COUNT Mandelbrot iteration counts from the GPU core over a valid/ready handshake and buffers them in a small FIFO.
- Issues each batch to the frame buffer as a one-cycle valid pulse, paced so the buffer's sequential writer is never overrun, with a stable column-major base write address.
- After the last batch of a frame has been written, pulses swap on the next vsync rising edge so the frame buffer swaps halves without tearing.

---
 rtl/gpu_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 66 ++++++
 rtl/frame_write_sequencer.sv | 152 +++++++++++++++
 tb/tb_frame_write_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared defaults, derived sizes and sequencer state encoding for the GPU frame path.
package gpu_pkg;

  parameter int unsigned DEF_FMA_COUNT  = 2;
  parameter int unsigned DEF_ITERS_BITS = 4;
  parameter int unsigned DEF_WIDTH      = 320;
  parameter int unsigned DEF_HEIGHT     = 320;

  localparam int unsigned PIXELS    = DEF_WIDTH * DEF_HEIGHT;
  localparam int unsigned ADDR_BITS = $clog2(PIXELS);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    WAIT_SWAP,
    SWAP
  } fws_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head data and a synchronous flush.
module sync_fifo #(
  parameter int unsigned WIDTH_BITS = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [WIDTH_BITS-1:0] din,
  output logic                  full,
  output logic                  empty,
  output logic [WIDTH_BITS-1:0] dout
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH_BITS-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]         count_q, count_d;

  assign full  = (count_q == (PtrW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  // Pointer and occupancy update; flush wins over any push/pop in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/frame_write_sequencer.sv
// Buffers GPU iteration batches and paces them into the dual frame buffer, swapping on vsync.
module frame_write_sequencer
  import gpu_pkg::*;
#(
  parameter int unsigned FMA_COUNT  = DEF_FMA_COUNT,
  parameter int unsigned ITERS_BITS = DEF_ITERS_BITS,
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned HEIGHT     = DEF_HEIGHT,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                                sys_clk_in,
  input  logic                                rst_n_in,
  input  logic                                batch_valid_in,
  input  logic [FMA_COUNT*ITERS_BITS-1:0]     batch_iters_in,
  output logic                                batch_ready_out,
  input  logic                                vsync_in,
  input  logic                                frame_restart_in,
  output logic                                mandelbrot_iters_valid_out,
  output logic [FMA_COUNT*ITERS_BITS-1:0]     mandelbrot_iters_out,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]     addr_write_out,
  output logic                                swap_out,
  output logic [15:0]                         frame_count_out
);

  localparam int unsigned NumPix = WIDTH * HEIGHT;
  localparam int unsigned AddrW  = $clog2(NumPix);
  localparam int unsigned DataW  = FMA_COUNT * ITERS_BITS;
  localparam int unsigned CntW   = (FMA_COUNT > 1) ? $clog2(FMA_COUNT) : 1;

  fws_state_t       state_q, state_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [DataW-1:0] data_q, data_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             vsync_q;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [DataW-1:0] fifo_dout;
  logic [AddrW:0]   addr_next;
  logic             frame_last;
  logic             vsync_rise;

  // Ready is forced low during reset so nothing is accepted before the FIFO is usable.
  assign batch_ready_out = rst_n_in && !fifo_full && !frame_restart_in;
  assign fifo_push       = batch_valid_in && batch_ready_out;

  // One extra bit so the end-of-frame compare cannot wrap.
  assign addr_next  = {1'b0, addr_q} + (AddrW+1)'(FMA_COUNT);
  assign frame_last = (addr_next == (AddrW+1)'(NumPix));
  assign vsync_rise = vsync_in && !vsync_q;

  assign mandelbrot_iters_valid_out = (state_q == ISSUE);
  assign swap_out                   = (state_q == SWAP);
  assign mandelbrot_iters_out       = data_q;
  assign addr_write_out             = addr_q;
  assign frame_count_out            = frame_cnt_q;

  sync_fifo #(
    .WIDTH_BITS (DataW),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sys_clk_in),
    .rst_n (rst_n_in),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (frame_restart_in),
    .din   (batch_iters_in),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  // Next-state logic: pop, issue, drain, then either advance or wait for vsync to swap.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    pending_d   = pending_q;
    frame_cnt_d = frame_cnt_q;
    fifo_pop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (frame_restart_in) begin
          addr_d = '0;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          data_d   = fifo_dout;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (frame_restart_in) pending_d = 1'b1;
        cnt_d   = CntW'(FMA_COUNT - 1);
        state_d = DRAIN;
      end
      DRAIN: begin
        if (frame_restart_in) pending_d = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (pending_q || frame_restart_in) begin
          // An abort seen during the write finishes the drain, then restarts the frame.
          pending_d = 1'b0;
          addr_d    = '0;
          state_d   = IDLE;
        end else if (frame_last) begin
          state_d = WAIT_SWAP;
        end else begin
          addr_d  = addr_next[AddrW-1:0];
          state_d = IDLE;
        end
      end
      WAIT_SWAP: begin
        if (frame_restart_in) begin
          addr_d  = '0;
          state_d = IDLE;
        end else if (vsync_rise) begin
          state_d = SWAP;
        end
      end
      SWAP: begin
        frame_cnt_d = frame_cnt_q + 16'd1;
        addr_d      = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, output and vsync-history registers.
  always_ff @(posedge sys_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      vsync_q     <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      vsync_q     <= vsync_in;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_frame_write_sequencer.sv
// Directed bench for frame_write_sequencer on a 4x4 frame with two-lane batches.
module tb_frame_write_sequencer;

  localparam int unsigned Fma = 2;
  localparam int unsigned Ib  = 4;
  localparam int unsigned W   = 4;
  localparam int unsigned H   = 4;
  localparam int unsigned Fd  = 4;
  localparam int unsigned Dw  = Fma * Ib;
  localparam int unsigned Aw  = $clog2(W * H);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          bv = 1'b0;
  logic [Dw-1:0] bd = '0;
  logic          ready;
  logic          vsync = 1'b0;
  logic          restart = 1'b0;
  logic          valid_out;
  logic [Dw-1:0] data_out;
  logic [Aw-1:0] addr_out;
  logic          swap;
  logic [15:0]   frame_cnt;

  int checks = 0;
  int errors = 0;
  int swaps  = 0;
  int pulses = 0;

  frame_write_sequencer #(
    .FMA_COUNT  (Fma),
    .ITERS_BITS (Ib),
    .WIDTH      (W),
    .HEIGHT     (H),
    .FIFO_DEPTH (Fd)
  ) dut (
    .sys_clk_in                 (clk),
    .rst_n_in                   (rst_n),
    .batch_valid_in             (bv),
    .batch_iters_in             (bd),
    .batch_ready_out            (ready),
    .vsync_in                   (vsync),
    .frame_restart_in           (restart),
    .mandelbrot_iters_valid_out (valid_out),
    .mandelbrot_iters_out       (data_out),
    .addr_write_out             (addr_out),
    .swap_out                   (swap),
    .frame_count_out            (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the edge, tallying pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    if (swap) swaps++;
    if (valid_out) pulses++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sent;
    int seen;
    int p0;
    bit ready_low;
    bit hit6;

    // Reset state.
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_ready", 32'(ready), 32'd0);
    check_eq("rst_valid", 32'(valid_out), 32'd0);
    check_eq("rst_swap", 32'(swap), 32'd0);
    check_eq("rst_frame", 32'(frame_cnt), 32'd0);
    check_eq("rst_addr", 32'(addr_out), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("ready_after_rst", 32'(ready), 32'd1);

    // Single batch latency and spacing.
    bv = 1'b1; bd = 8'hA5;
    tick();
    bv = 1'b0;
    check_eq("lat_t0_valid", 32'(valid_out), 32'd0);
    tick();
    check_eq("lat_t1_valid", 32'(valid_out), 32'd1);
    check_eq("lat_t1_data", 32'(data_out), 32'hA5);
    check_eq("lat_t1_addr", 32'(addr_out), 32'd0);
    tick();
    check_eq("drain1_valid", 32'(valid_out), 32'd0);
    tick();
    check_eq("drain2_valid", 32'(valid_out), 32'd0);
    tick();
    check_eq("addr_step", 32'(addr_out), 32'd2);

    // Second batch, then async reset in the middle of its drain.
    bv = 1'b1; bd = 8'h3C;
    tick();
    bv = 1'b0;
    tick();
    check_eq("b2_valid", 32'(valid_out), 32'd1);
    check_eq("b2_data", 32'(data_out), 32'h3C);
    check_eq("b2_addr", 32'(addr_out), 32'd2);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 32'(valid_out), 32'd0);
    check_eq("arst_data", 32'(data_out), 32'd0);
    check_eq("arst_addr", 32'(addr_out), 32'd0);
    check_eq("arst_ready", 32'(ready), 32'd0);
    check_eq("arst_swap", 32'(swap), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_valid", 32'(valid_out), 32'd0);
    check_eq("post_rst_addr", 32'(addr_out), 32'd0);

    // Eight back-to-back batches filling one frame.
    swaps = 0;
    sent = 0;
    seen = 0;
    ready_low = 1'b0;
    for (int c = 0; c < 80 && seen < 8; c++) begin
      bit acc;
      bv = (sent < 8);
      bd = 8'(8'h10 + sent);
      if (bv && !ready) ready_low = 1'b1;
      acc = bv && ready;
      tick();
      if (acc) sent++;
      if (valid_out) begin
        check_eq($sformatf("b2b_addr%0d", seen), 32'(addr_out), 32'(2 * seen));
        check_eq($sformatf("b2b_data%0d", seen), 32'(data_out), 32'(8'h10 + seen));
        seen++;
      end
    end
    bv = 1'b0;
    check_eq("b2b_count", 32'(seen), 32'd8);
    check_eq("b2b_ready_drop", 32'(ready_low), 32'd1);
    check_eq("b2b_no_swap", 32'(swaps), 32'd0);

    // vsync rising during the final drain is ignored.
    tick();
    vsync = 1'b1;
    tick();
    tick();
    vsync = 1'b0;
    check_eq("vs_drain_swap", 32'(swaps), 32'd0);

    // A batch accepted while waiting for vsync must not be issued yet.
    check_eq("ws_ready", 32'(ready), 32'd1);
    bv = 1'b1; bd = 8'hE7;
    tick();
    bv = 1'b0;
    p0 = pulses;
    for (int i = 0; i < 9; i++) tick();
    check_eq("ws_no_swap", 32'(swaps), 32'd0);
    check_eq("ws_no_issue", 32'(pulses), 32'(p0));
    vsync = 1'b1;
    tick();
    check_eq("swap_pulse", 32'(swap), 32'd1);
    tick();
    vsync = 1'b0;
    check_eq("swap_end", 32'(swap), 32'd0);
    check_eq("frame_cnt1", 32'(frame_cnt), 32'd1);
    tick();
    check_eq("nf_valid", 32'(valid_out), 32'd1);
    check_eq("nf_data", 32'(data_out), 32'hE7);
    check_eq("nf_addr", 32'(addr_out), 32'd0);
    check_eq("swap_once", 32'(swaps), 32'd1);

    // Restart during the drain of addr 6 with two batches queued.
    sent = 0;
    hit6 = 1'b0;
    for (int c = 0; c < 40 && !hit6; c++) begin
      bit acc;
      bv = (sent < 5);
      bd = 8'(8'h21 + sent);
      acc = bv && ready;
      tick();
      if (acc) sent++;
      if (valid_out && addr_out == 4'd6) begin
        hit6 = 1'b1;
        check_eq("r_data6", 32'(data_out), 32'h23);
      end
    end
    bv = 1'b0;
    check_eq("r_hit6", 32'(hit6), 32'd1);
    check_eq("r_sent", 32'(sent), 32'd5);
    tick();
    restart = 1'b1;
    bv = 1'b1; bd = 8'hFF;
    #1;
    check_eq("r_ready", 32'(ready), 32'd0);
    tick();
    restart = 1'b0;
    bv = 1'b0;
    p0 = pulses;
    for (int i = 0; i < 6; i++) tick();
    check_eq("r_flushed", 32'(pulses), 32'(p0));
    check_eq("r_addr0", 32'(addr_out), 32'd0);
    bv = 1'b1; bd = 8'h5A;
    tick();
    bv = 1'b0;
    tick();
    check_eq("r_next_valid", 32'(valid_out), 32'd1);
    check_eq("r_next_data", 32'(data_out), 32'h5A);
    check_eq("r_next_addr", 32'(addr_out), 32'd0);
    check_eq("r_no_swap", 32'(swaps), 32'd1);
    check_eq("r_frame_cnt", 32'(frame_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
